imem_program_loader: RTL

//  Write-side counterpart to the pipeline's instruction fetch: streams a program image

---
 rtl/imem_program_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/imem_program_loader.sv
// Streams a big-endian program image from a byte handshake into instruction memory,
// holding the core in reset until the whole image has been written.
module imem_program_loader #(
  parameter int              ISIZE     = 32,
  parameter int              AW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int              MAX_WORDS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_addr,
  output logic [ISIZE-1:0] mem_wdata,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BPW = ISIZE / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic             err_nxt;
  logic             hdr_cnt;
  logic [7:0]       n_hi;
  logic [15:0]      n_words;
  logic [15:0]      word_cnt;
  logic [BCW-1:0]   byte_cnt;
  logic [ISIZE-9:0] word_reg;
  logic [ISIZE-1:0] word_nxt;
  logic [15:0]      hdr_n;
  logic             accept;
  logic             last_word;

  assign accept    = in_valid && in_ready;
  assign hdr_n     = {n_hi, in_data};
  // word_reg holds only the earlier bytes; the incoming byte completes the word
  assign word_nxt  = {word_reg, in_data};
  assign last_word = ({1'b0, word_cnt} + 17'd1) == {1'b0, n_words};

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = HDR;
          err_nxt   = 1'b0;
        end
      end
      HDR: begin
        if (accept && hdr_cnt) begin
          if (hdr_n == 16'd0) begin
            state_nxt = DONE;
          end else if ({16'd0, hdr_n} > 32'(MAX_WORDS)) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (accept && (byte_cnt == LAST_BYTE)) state_nxt = WRITE;
      end
      WRITE:   state_nxt = last_word ? DONE : DATA;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_rst   <= 1'b1;
      hdr_cnt   <= 1'b0;
      n_hi      <= '0;
      n_words   <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      word_reg  <= '0;
    end else begin
      state    <= state_nxt;
      err      <= err_nxt;
      in_ready <= (state_nxt == HDR) || (state_nxt == DATA);
      mem_wen  <= (state_nxt == WRITE);
      busy     <= (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == WRITE);
      done     <= (state_nxt == DONE);
      cpu_rst  <= (state_nxt == DONE) ? err_nxt : 1'b1;

      if (state_nxt == WRITE) begin
        mem_addr  <= BASE_ADDR + AW'(word_cnt);
        mem_wdata <= word_nxt;
      end

      case (state)
        IDLE, DONE: begin
          if (start) hdr_cnt <= 1'b0;
        end
        HDR: begin
          if (accept) begin
            if (!hdr_cnt) begin
              n_hi    <= in_data;
              hdr_cnt <= 1'b1;
            end else begin
              n_words  <= hdr_n;
              word_cnt <= '0;
              byte_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word_reg <= word_nxt[ISIZE-9:0];
            byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
          end
        end
        WRITE:   word_cnt <= word_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
